// File: rtl/mac_accumulator.sv
// Multiply-accumulate back end: sums LEN products from the array multiplier into a
// saturating ACC_W-bit accumulator and hands the frame sum out over valid/ready.
module mac_accumulator #(
    parameter int unsigned N     = 8,
    parameter int unsigned M     = 8,
    parameter int unsigned ACC_W = 24,
    parameter int unsigned LEN   = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         clr,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [N+M-1:0]               prod,
    input  logic                         sg,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [ACC_W-1:0]             acc_out,
    output logic                         ovf,
    output logic [$clog2(LEN+1)-1:0]     cnt
);

    localparam int unsigned P_W   = N + M;
    localparam int unsigned CNT_W = $clog2(LEN + 1);
    localparam int unsigned EXT_W = ACC_W + 1;

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_e;

    state_e             state_q;
    logic [ACC_W-1:0]   acc_q;
    logic [ACC_W-1:0]   acc_d;
    logic [CNT_W-1:0]   cnt_q;
    logic               ovf_q;
    logic               mode_q;
    logic               in_ready_q;
    logic               out_valid_q;

    logic               take_c;
    logic               mode_c;
    logic               clamp_c;
    logic [EXT_W-1:0]   acc_ext;
    logic [EXT_W-1:0]   prod_ext;
    logic [EXT_W-1:0]   sum_ext;

    // Extend, add one bit wider than the accumulator, then clamp to the mode's range.
    always_comb begin
        take_c   = in_valid && in_ready_q;
        mode_c   = (cnt_q == '0) ? sg : mode_q;
        acc_ext  = {1'b0, acc_q};
        prod_ext = {{(EXT_W-P_W){1'b0}}, prod};
        if (mode_c) begin
            acc_ext  = {acc_q[ACC_W-1], acc_q};
            prod_ext = {{(EXT_W-P_W){prod[P_W-1]}}, prod};
        end
        sum_ext = acc_ext + prod_ext;
        clamp_c = 1'b0;
        acc_d   = sum_ext[ACC_W-1:0];
        if (mode_c) begin
            if (sum_ext[ACC_W] != sum_ext[ACC_W-1]) begin
                clamp_c = 1'b1;
                acc_d   = sum_ext[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}}
                                         : {1'b0, {(ACC_W-1){1'b1}}};
            end
        end else if (sum_ext[ACC_W]) begin
            clamp_c = 1'b1;
            acc_d   = '1;
        end
    end

    // Frame FSM; handshake outputs are registered decodes of the next state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ACCUM;
            acc_q       <= '0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            mode_q      <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else if (clr) begin
            state_q     <= ACCUM;
            acc_q       <= '0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            mode_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                ACCUM: begin
                    in_ready_q <= 1'b1;
                    if (take_c) begin
                        acc_q  <= acc_d;
                        cnt_q  <= cnt_q + CNT_W'(1);
                        ovf_q  <= ovf_q | clamp_c;
                        mode_q <= mode_c;
                        if (cnt_q == CNT_W'(LEN - 1)) begin
                            state_q     <= HOLD;
                            in_ready_q  <= 1'b0;
                            out_valid_q <= 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        state_q     <= ACCUM;
                        acc_q       <= '0;
                        cnt_q       <= '0;
                        ovf_q       <= 1'b0;
                        in_ready_q  <= 1'b1;
                        out_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ACCUM;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign acc_out   = acc_q;
    assign ovf       = ovf_q;
    assign cnt       = cnt_q;

endmodule

// File: tb/tb_mac_accumulator.sv
// Bench for mac_accumulator: three configurations share one directed stimulus stream,
// each checked every cycle against an integer-arithmetic frame model plus literal pins.
module tb_mac_accumulator;

    logic        clk = 1'b0;
    logic        rst_n, clr, in_valid, sg, out_ready;
    logic [15:0] prod;

    logic        ir_a, ov_a, vf_a, ir_b, ov_b, vf_b, ir_c, ov_c, vf_c;
    logic [23:0] acc_a, acc_c;
    logic [15:0] acc_b;
    logic [2:0]  cnt_a, cnt_b;
    logic [0:0]  cnt_c;

    int n_pass  = 0;
    int n_total = 0;
    bit model_on = 1'b0;

    always #5 clk = ~clk;

    mac_accumulator #(.N(8), .M(8), .ACC_W(24), .LEN(4)) u_a (
        .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(ir_a),
        .prod(prod), .sg(sg), .out_valid(ov_a), .out_ready(out_ready),
        .acc_out(acc_a), .ovf(vf_a), .cnt(cnt_a));

    mac_accumulator #(.N(8), .M(8), .ACC_W(16), .LEN(4)) u_b (
        .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(ir_b),
        .prod(prod), .sg(sg), .out_valid(ov_b), .out_ready(out_ready),
        .acc_out(acc_b), .ovf(vf_b), .cnt(cnt_b));

    mac_accumulator #(.N(8), .M(8), .ACC_W(24), .LEN(1)) u_c (
        .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(ir_c),
        .prod(prod), .sg(sg), .out_valid(ov_c), .out_ready(out_ready),
        .acc_out(acc_c), .ovf(vf_c), .cnt(cnt_c));

    typedef struct {
        bit     rdy;
        bit     vld;
        longint acc;
        int     cnt;
        bit     ovf;
        bit     mode;
    } mdl_t;

    mdl_t ma, mb, mc;

    // Frame-level model: signed integer sum clamped to the numeric range of the mode.
    function automatic mdl_t step(input mdl_t s, input int aw, input int len);
        mdl_t   n;
        longint p, sum, lo, hi;
        bit     m;
        n = s;
        if (!rst_n) begin
            n = '{default: 0};
        end else if (clr) begin
            n = '{default: 0};
            n.rdy = 1'b1;
        end else if (s.vld) begin
            if (out_ready) begin
                n = '{default: 0};
                n.rdy = 1'b1;
            end
        end else if (!s.rdy) begin
            n.rdy = 1'b1;
        end else if (in_valid) begin
            m   = (s.cnt == 0) ? sg : s.mode;
            p   = m ? longint'($signed(prod)) : longint'({48'd0, prod});
            sum = s.acc + p;
            if (m) begin
                lo = -(longint'(1) <<< (aw - 1));
                hi = (longint'(1) <<< (aw - 1)) - 1;
            end else begin
                lo = 0;
                hi = (longint'(1) <<< aw) - 1;
            end
            if (sum > hi) begin sum = hi; n.ovf = 1'b1; end
            if (sum < lo) begin sum = lo; n.ovf = 1'b1; end
            n.acc  = sum;
            n.mode = m;
            n.cnt  = s.cnt + 1;
            if (n.cnt == len) begin
                n.rdy = 1'b0;
                n.vld = 1'b1;
            end
        end
        return n;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", nm, act, exp, $time);
    endtask

    task automatic cmp(input string tag, input mdl_t e, input int aw, input logic ir,
                       input logic ov, input logic [23:0] acc, input logic vf, input int c);
        longint mask;
        mask = (longint'(1) <<< aw) - 1;
        chk({tag, ".in_ready"},  64'(ir),  64'(e.rdy));
        chk({tag, ".out_valid"}, 64'(ov),  64'(e.vld));
        chk({tag, ".acc_out"},   64'(acc), 64'(e.acc & mask));
        chk({tag, ".ovf"},       64'(vf),  64'(e.ovf));
        chk({tag, ".cnt"},       64'(c),   64'(e.cnt));
    endtask

    always @(posedge clk) begin
        ma = step(ma, 24, 4);
        mb = step(mb, 16, 4);
        mc = step(mc, 24, 1);
        if (!rst_n) model_on = 1'b1;
    end

    always @(negedge clk) begin
        if (model_on) begin
            cmp("a", ma, 24, ir_a, ov_a, acc_a, vf_a, int'(cnt_a));
            cmp("b", mb, 16, ir_b, ov_b, {8'd0, acc_b}, vf_b, int'(cnt_b));
            cmp("c", mc, 24, ir_c, ov_c, acc_c, vf_c, int'(cnt_c));
        end
    end

    // Present one product and hold it until configuration a accepts it.
    task automatic send(input logic [15:0] p, input logic s);
        int guard;
        guard    = 0;
        in_valid = 1'b1;
        prod     = p;
        sg       = s;
        while (!ir_a && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 50) chk("send_timeout", 64'd0, 64'd1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; prod = '0; sg = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        chk("reset.acc", 64'(acc_a), 64'd0);
        chk("reset.in_ready", 64'(ir_a), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Unsigned frame
        send(16'd100, 1'b0); send(16'd200, 1'b0); send(16'd300, 1'b0); send(16'd400, 1'b0);
        chk("t1.out_valid", 64'(ov_a), 64'd1);
        chk("t1.acc", 64'(acc_a), 64'd1000);
        chk("t1.ovf", 64'(vf_a), 64'd0);
        chk("t1.cnt", 64'(cnt_a), 64'd4);
        chk("t1.in_ready_low", 64'(ir_a), 64'd0);
        @(negedge clk);
        chk("t1.out_valid_drop", 64'(ov_a), 64'd0);
        chk("t1.in_ready_back", 64'(ir_a), 64'd1);

        // Signed frame, sign taken from first term only
        send(16'hC080, 1'b1); send(16'h0001, 1'b0); send(16'hFFFF, 1'b0); send(16'h0010, 1'b0);
        chk("t2.acc", 64'(acc_a), 64'hFFC090);
        chk("t2.acc16", 64'(acc_b), 64'hC090);
        chk("t2.ovf", 64'(vf_a), 64'd0);
        @(negedge clk);

        // Saturation on the 16-bit accumulator
        repeat (4) send(16'hFFFF, 1'b0);
        chk("t3.u_acc16", 64'(acc_b), 64'hFFFF);
        chk("t3.u_ovf16", 64'(vf_b), 64'd1);
        chk("t3.u_acc24", 64'(acc_a), 64'd262140);
        @(negedge clk);
        chk("t3.ovf_cleared", 64'(vf_b), 64'd0);
        repeat (4) send(16'h8000, 1'b1);
        chk("t3.s_acc16", 64'(acc_b), 64'h8000);
        chk("t3.s_ovf16", 64'(vf_b), 64'd1);
        chk("t3.s_acc24", 64'(acc_a), 64'hFE0000);
        @(negedge clk);

        // Backpressure with a product parked on the input
        out_ready = 1'b0;
        send(16'd1, 1'b0); send(16'd2, 1'b0); send(16'd3, 1'b0); send(16'd4, 1'b0);
        chk("t4.ovf_next_frame", 64'(vf_b), 64'd0);
        in_valid = 1'b1; prod = 16'd7; sg = 1'b0;
        repeat (5) begin
            @(negedge clk);
            chk("t4.hold_valid", 64'(ov_a), 64'd1);
            chk("t4.hold_acc", 64'(acc_a), 64'd10);
            chk("t4.hold_cnt", 64'(cnt_a), 64'd4);
        end
        out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        chk("t4.first_term_cnt", 64'(cnt_a), 64'd1);
        chk("t4.first_term_acc", 64'(acc_a), 64'd7);
        send(16'd1, 1'b0); send(16'd1, 1'b0); send(16'd1, 1'b0);
        chk("t4.acc", 64'(acc_a), 64'd10);
        @(negedge clk);

        // Clear mid-frame with a simultaneous input, then clear during HOLD
        send(16'd5, 1'b0); send(16'd6, 1'b0);
        clr = 1'b1; in_valid = 1'b1; prod = 16'd9;
        @(negedge clk);
        clr = 1'b0; in_valid = 1'b0;
        chk("t5.cnt", 64'(cnt_a), 64'd0);
        chk("t5.acc", 64'(acc_a), 64'd0);
        send(16'd10, 1'b0); send(16'd20, 1'b0); send(16'd30, 1'b0); send(16'd40, 1'b0);
        chk("t5.acc_fresh", 64'(acc_a), 64'd100);
        @(negedge clk);
        repeat (4) send(16'd1, 1'b0);
        chk("t5.hold_valid", 64'(ov_a), 64'd1);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        chk("t5.hold_clr_valid", 64'(ov_a), 64'd0);
        chk("t5.hold_clr_acc", 64'(acc_a), 64'd0);

        // Reset mid-frame, then mode latch from first term
        send(16'd3, 1'b0); send(16'd3, 1'b0);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("t6.rst_acc", 64'(acc_a), 64'd0);
        chk("t6.rst_cnt", 64'(cnt_a), 64'd0);
        chk("t6.rst_in_ready", 64'(ir_a), 64'd0);
        chk("t6.rst_valid", 64'(ov_a), 64'd0);
        send(16'hFFFF, 1'b0); send(16'hFFFF, 1'b1); send(16'hFFFF, 1'b1); send(16'hFFFF, 1'b1);
        chk("t6.acc", 64'(acc_a), 64'd262140);
        chk("t6.ovf", 64'(vf_a), 64'd0);
        repeat (3) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", n_pass, n_total);
        $fatal(1);
    end

endmodule
